// File: rtl/rgb_gray_pkg.sv
// rtl/rgb_gray_pkg.sv - shared constants for the RGB-to-grey stream converter
package rgb_gray_pkg;

    localparam int GRAY_W = 8;

    localparam logic [1:0] MODE_GRAY   = 2'd0;
    localparam logic [1:0] MODE_BINARY = 2'd1;
    localparam logic [1:0] MODE_INVERT = 2'd2;

    localparam logic [7:0] COEF_R_DEF = 8'd77;
    localparam logic [7:0] COEF_G_DEF = 8'd150;
    localparam logic [7:0] COEF_B_DEF = 8'd29;

endpackage

// File: rtl/rgb_chan_expand.sv
// rtl/rgb_chan_expand.sv - widen one colour channel to 8 bits by MSB replication
module rgb_chan_expand #(
    parameter int CH_W = 4
) (
    input  logic [CH_W-1:0] c,
    output logic [7:0]      c8
);

    // Repeating the channel pattern from the MSB down maps full-scale to 0xFF exactly.
    always_comb begin
        c8 = '0;
        for (int i = 0; i < 8; i++) begin
            c8[7-i] = c[CH_W-1-(i % CH_W)];
        end
    end

endmodule

// File: rtl/rgb_to_gray_stream.sv
// rtl/rgb_to_gray_stream.sv - 3-stage RGB to grey/binary/inverted pixel stream with backpressure
module rgb_to_gray_stream
    import rgb_gray_pkg::*;
#(
    parameter int CH_W   = 4,
    parameter int OUT_W  = 8,
    parameter int COEF_W = 8,
    parameter int USER_W = 1,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [3*CH_W-1:0]   s_rgb,
    input  logic [USER_W-1:0]   s_user,
    input  logic [COEF_W-1:0]   cfg_coef_r,
    input  logic [COEF_W-1:0]   cfg_coef_g,
    input  logic [COEF_W-1:0]   cfg_coef_b,
    input  logic [1:0]          cfg_mode,
    input  logic [7:0]          cfg_thresh,
    input  logic                stat_clr,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [OUT_W-1:0]    m_gray,
    output logic [USER_W-1:0]   m_user,
    output logic [CNT_W-1:0]    pix_count
);

    localparam int P_W   = GRAY_W + COEF_W;
    localparam int SUM_W = P_W + 2;
    localparam logic [SUM_W-1:0] ROUND = SUM_W'(1) << (COEF_W - 1);

    logic                adv;
    logic [7:0]          c8_r, c8_g, c8_b;

    logic                v1;
    logic [P_W-1:0]      p1_r, p1_g, p1_b;
    logic [USER_W-1:0]   u1;
    logic [1:0]          mode1;
    logic [7:0]          thr1;

    logic                v2;
    logic [7:0]          y2;
    logic [USER_W-1:0]   u2;
    logic [1:0]          mode2;
    logic [7:0]          thr2;

    logic [SUM_W-1:0]    sum_rnd;
    logic [SUM_W-1:0]    y_full;
    logic [7:0]          y_sat;
    logic [7:0]          res8;

    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;

    rgb_chan_expand #(.CH_W(CH_W)) u_exp_r (.c(s_rgb[3*CH_W-1:2*CH_W]), .c8(c8_r));
    rgb_chan_expand #(.CH_W(CH_W)) u_exp_g (.c(s_rgb[2*CH_W-1:CH_W]),   .c8(c8_g));
    rgb_chan_expand #(.CH_W(CH_W)) u_exp_b (.c(s_rgb[CH_W-1:0]),        .c8(c8_b));

    always_comb begin
        sum_rnd = {2'b00, p1_r} + {2'b00, p1_g} + {2'b00, p1_b} + ROUND;
        y_full  = sum_rnd >> COEF_W;
        y_sat   = (y_full > SUM_W'(255)) ? 8'hFF : y_full[7:0];
    end

    // Mode and threshold travel with the pixel so config changes never hit in-flight data.
    always_comb begin
        res8 = y2;
        case (mode2)
            MODE_BINARY: res8 = (y2 >= thr2) ? 8'hFF : 8'h00;
            MODE_INVERT: res8 = 8'hFF - y2;
            default:     res8 = y2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            p1_r    <= '0;
            p1_g    <= '0;
            p1_b    <= '0;
            u1      <= '0;
            mode1   <= MODE_GRAY;
            thr1    <= '0;
            v2      <= 1'b0;
            y2      <= '0;
            u2      <= '0;
            mode2   <= MODE_GRAY;
            thr2    <= '0;
            m_valid <= 1'b0;
            m_gray  <= '0;
            m_user  <= '0;
        end else if (adv) begin
            v1      <= s_valid;
            p1_r    <= {{COEF_W{1'b0}}, c8_r} * {8'b0, cfg_coef_r};
            p1_g    <= {{COEF_W{1'b0}}, c8_g} * {8'b0, cfg_coef_g};
            p1_b    <= {{COEF_W{1'b0}}, c8_b} * {8'b0, cfg_coef_b};
            u1      <= s_user;
            mode1   <= cfg_mode;
            thr1    <= cfg_thresh;
            v2      <= v1;
            y2      <= y_sat;
            u2      <= u1;
            mode2   <= mode1;
            thr2    <= thr1;
            m_valid <= v2;
            m_gray  <= res8[GRAY_W-1 -: OUT_W];
            m_user  <= u2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            pix_count <= '0;
        end else if (m_valid && m_ready) begin
            pix_count <= pix_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// tb/tb_rgb_to_gray_stream.sv - self-checking bench for rgb_to_gray_stream
module tb_rgb_to_gray_stream;
    import rgb_gray_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_rgb;
    logic [0:0]  s_user;
    logic [7:0]  cfg_coef_r, cfg_coef_g, cfg_coef_b;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_thresh;
    logic        stat_clr;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_gray;
    logic [0:0]  m_user;
    logic [31:0] pix_count;

    rgb_to_gray_stream #(.CH_W(4), .OUT_W(8), .COEF_W(8), .USER_W(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_rgb(s_rgb),
        .s_user(s_user), .cfg_coef_r(cfg_coef_r), .cfg_coef_g(cfg_coef_g),
        .cfg_coef_b(cfg_coef_b), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .stat_clr(stat_clr), .m_valid(m_valid), .m_ready(m_ready), .m_gray(m_gray),
        .m_user(m_user), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gray;
        logic       user;
        int         xcyc;
        bit         lat;
    } exp_t;

    typedef struct {
        logic [11:0] rgb;
        logic [7:0]  cr, cg, cb;
        logic [1:0]  mode;
        logic [7:0]  thr;
        logic [7:0]  exp_gray;
    } vec_t;

    exp_t       sb[$];
    exp_t       e_mon;
    vec_t       vecs[12];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         deliv = 0;
    bit         prev_stall = 0;
    bit         saw_full_stall = 0;
    logic [7:0] prev_gray;
    logic       prev_user;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model(input logic [11:0] rgb, input logic [7:0] cr,
                                         input logic [7:0] cg, input logic [7:0] cb,
                                         input logic [1:0] mode, input logic [7:0] thr);
        int r, g, b, s, y;
        r = int'(rgb[11:8]) * 17;
        g = int'(rgb[7:4]) * 17;
        b = int'(rgb[3:0]) * 17;
        s = r * int'(cr) + g * int'(cg) + b * int'(cb);
        y = (s + 128) / 256;
        if (y > 255) y = 255;
        if (mode == 2'd1) y = (y >= int'(thr)) ? 255 : 0;
        else if (mode == 2'd2) y = 255 - y;
        return y[7:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Output monitor: scoreboard pop, latency, stall stability and s_ready-under-stall.
    always @(negedge clk) begin
        if (!rst && m_valid && !m_ready) begin
            checks++;
            if (s_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_s_ready: got %0b expected 0", s_ready);
            end else begin
                saw_full_stall = 1;
            end
        end
        if (!rst && prev_stall && m_valid) begin
            checks++;
            if (m_gray !== prev_gray || m_user !== prev_user) begin
                errors++;
                $display("FAIL stall_stable: got %0d/%0b expected %0d/%0b",
                         m_gray, m_user, prev_gray, prev_user);
            end
        end
        prev_stall = !rst && m_valid && !m_ready;
        prev_gray  = m_gray;
        prev_user  = m_user;
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0d expected no pixel", m_gray);
            end else begin
                e_mon = sb.pop_front();
                if (m_gray !== e_mon.gray || m_user !== e_mon.user) begin
                    errors++;
                    $display("FAIL pixel: got %0d/%0b expected %0d/%0b",
                             m_gray, m_user, e_mon.gray, e_mon.user);
                end
                if (e_mon.lat) begin
                    checks++;
                    if (cyc - e_mon.xcyc != 3) begin
                        errors++;
                        $display("FAIL latency: got %0d expected 3", cyc - e_mon.xcyc);
                    end
                end
            end
            deliv++;
        end
    end

    task automatic send(input logic [11:0] rgb, input logic [7:0] cr, input logic [7:0] cg,
                        input logic [7:0] cb, input logic [1:0] mode, input logic [7:0] thr,
                        input logic [7:0] exp_gray, input bit lat, input bit push);
        exp_t e;
        int   n;
        s_rgb      = rgb;
        cfg_coef_r = cr;
        cfg_coef_g = cg;
        cfg_coef_b = cb;
        cfg_mode   = mode;
        cfg_thresh = thr;
        s_user     = 1'($urandom_range(0, 1));
        s_valid    = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got s_ready 0 expected 1");
                s_valid = 1'b0;
                return;
            end
        end
        if (push) begin
            e.gray = exp_gray;
            e.user = s_user;
            e.xcyc = cyc;
            e.lat  = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] rgb;
        logic [1:0]  md;
        logic [7:0]  th;
        int          n;

        vecs[0]  = '{12'hFFF, 8'd77, 8'd150, 8'd29, MODE_GRAY,   8'd0,   8'd255};
        vecs[1]  = '{12'h000, 8'd77, 8'd150, 8'd29, MODE_GRAY,   8'd0,   8'd0};
        vecs[2]  = '{12'hF00, 8'd77, 8'd150, 8'd29, MODE_GRAY,   8'd0,   8'd77};
        vecs[3]  = '{12'h0F0, 8'd77, 8'd150, 8'd29, MODE_BINARY, 8'd100, 8'd255};
        vecs[4]  = '{12'h00F, 8'd77, 8'd150, 8'd29, MODE_BINARY, 8'd100, 8'd0};
        vecs[5]  = '{12'h0F0, 8'd77, 8'd150, 8'd29, MODE_BINARY, 8'd149, 8'd255};
        vecs[6]  = '{12'h0F0, 8'd77, 8'd150, 8'd29, MODE_BINARY, 8'd150, 8'd0};
        vecs[7]  = '{12'hFFF, 8'd255, 8'd255, 8'd255, MODE_GRAY, 8'd0,   8'd255};
        vecs[8]  = '{12'hF00, 8'd77, 8'd150, 8'd29, MODE_INVERT, 8'd0,   8'd178};
        vecs[9]  = '{12'h0A5, 8'd77, 8'd150, 8'd29, MODE_GRAY,   8'd0,   8'd109};
        vecs[10] = '{12'hF00, 8'd77, 8'd150, 8'd29, 2'd3,        8'd0,   8'd77};
        vecs[11] = '{12'h000, 8'd77, 8'd150, 8'd29, MODE_BINARY, 8'd0,   8'd255};

        rst        = 1'b1;
        s_valid    = 1'b0;
        s_rgb      = '0;
        s_user     = '0;
        cfg_coef_r = COEF_R_DEF;
        cfg_coef_g = COEF_G_DEF;
        cfg_coef_b = COEF_B_DEF;
        cfg_mode   = MODE_GRAY;
        cfg_thresh = '0;
        stat_clr   = 1'b0;
        m_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_gray", 64'(m_gray), 64'd0);
        chk("rst_m_user", 64'(m_user), 64'd0);
        chk("rst_pix_count", 64'(pix_count), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;

        m_ready = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i].rgb, vecs[i].cr, vecs[i].cg, vecs[i].cb, vecs[i].mode,
                 vecs[i].thr, vecs[i].exp_gray, i == 0, 1'b1);
        end
        drain();

        for (int i = 0; i < 20; i++) begin
            rgb = 12'($urandom);
            md  = 2'($urandom_range(0, 3));
            th  = 8'($urandom);
            send(rgb, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, md, th,
                 model(rgb, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, md, th), 1'b0, 1'b1);
        end
        drain();

        saw_full_stall = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    rgb = 12'($urandom);
                    send(rgb, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, MODE_GRAY, 8'd0,
                         model(rgb, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, MODE_GRAY, 8'd0),
                         1'b0, 1'b1);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        drain();
        chk("bp_saw_stall", 64'(saw_full_stall), 64'd1);
        chk("bp_pix_count", 64'(pix_count), 64'(deliv));

        send(12'h0F0, 8'd77, 8'd150, 8'd29, MODE_GRAY, 8'd0, 8'd149, 1'b0, 1'b1);
        send(12'h0F0, 8'd77, 8'd0,   8'd29, MODE_GRAY, 8'd0, 8'd0,   1'b0, 1'b1);
        drain();

        send(12'hFFF, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, MODE_GRAY, 8'd0, 8'd255, 1'b0, 1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            if (m_valid && m_ready) break;
            n++;
            if (n > 20) break;
        end
        chk("clr_found_handshake", 64'(n <= 20), 64'd1);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        deliv    = 0;
        chk("clr_pix_count", 64'(pix_count), 64'd0);

        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(12'($urandom), COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, MODE_GRAY, 8'd0,
                 8'd0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        deliv = 0;
        chk("rstfly_m_valid", 64'(m_valid), 64'd0);
        chk("rstfly_pix_count", 64'(pix_count), 64'd0);
        chk("rstfly_s_ready", 64'(s_ready), 64'd1);
        m_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rstfly_no_stale", 64'(pix_count), 64'd0);

        send(12'hFFF, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, MODE_GRAY, 8'd0, 8'd255, 1'b1, 1'b1);
        drain();
        chk("final_pix_count", 64'(pix_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
